alu_result_uart_tx: RTL

- Downstream stage of the registered 4-bit ALU datapath. Consumes each 8-bit registered ALU result as a valid/ready word.
- Buffers words in a small FIFO and serialises them as 8N1 UART frames on one output pin, so results can be read off-chip through a single uo_out bit.
- Top level drives in_valid from a one-cycle "result ready" strobe.

---
 rtl/alu_result_uart_tx.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_result_uart_tx.sv
// -----------------------------------------------------------------------------
// alu_result_uart_tx
//
// Receives 8-bit ALU result words, buffers them in a small FIFO and sends each
// one as an 8N1 UART frame on a single serial pin. A frame is one start bit
// (low), eight data bits LSB first and one stop bit (high). Each bit lasts
// CLKS_PER_BIT clocks, so a frame lasts 10*CLKS_PER_BIT clocks. When another
// word is waiting at the end of a stop bit, the next start bit follows with
// no idle gap.
//
// Handshake: a word moves on the clk edge where in_valid && in_ready. in_ready
// is the registered "FIFO not full" flag and never depends on in_valid. If
// in_valid is high while in_ready is low, the word is dropped and overflow
// is set.
//
// Ports:
//   clk         clock
//   rst_n       synchronous active-low reset (flushes FIFO, aborts frame)
//   in_valid    producer offers in_data this cycle
//   in_data     ALU result word
//   in_ready    FIFO can accept a word (not full)
//   tx          UART serial line, registered, idles high
//   busy        a frame is in progress (FSM not IDLE)
//   fifo_count  number of words currently buffered
//   overflow    sticky: a word was offered while full (cleared by reset)
//   state_o     current FSM state, for observation
// -----------------------------------------------------------------------------
module alu_result_uart_tx #(
  parameter int CLKS_PER_BIT = 4,  // 1..65535
  parameter int DEPTH        = 4   // power of two, >= 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [1:0]               state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0]   BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  assign in_ready   = (count_q != FULL);
  assign push       = in_valid && in_ready;
  assign head       = mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

  // Storage has no reset; clearing the pointers empties the FIFO.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap when they overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (in_valid && !in_ready) overflow_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Serialiser FSM
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // tx_d is the line level for the state being entered. This keeps tx
  // registered and aligned with the state register.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = head;
          baud_d  = '0;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end

      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            // The next bit on the line is shift_q[1], which becomes
            // shift_q[0] once the register shifts.
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = head;
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  assign tx      = tx_q;
  assign busy    = (state_q != S_IDLE);
  assign state_o = state_q;

endmodule
